// File: rtl/full_adder_pkg.sv
// Shared constants and result record for the registered full adder.
// The record width is fixed by WIDTH where it is used.
package full_adder_pkg;

   localparam int FA_MAX_WIDTH = 64;
   localparam int FA_DEF_WIDTH = 1;

   typedef struct packed {
      logic                    cy;
      logic [FA_MAX_WIDTH-1:0] s;
   } fa_res_max_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder cell.
// Chained through ci/co to build the ripple-carry adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cy, s} = a + b + cin, one cycle latency.
// Registers load only on in_valid, so idle inputs never reach the outputs.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH = FA_DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cy,
   output logic             out_valid
);

   typedef struct packed {
      logic             cy;
      logic [WIDTH-1:0] s;
   } res_t;

   if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
      $error("full_adder: WIDTH out of range");
   end

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum;
   res_t             nxt;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_cell u_cell (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum[i]),
         .co (c[i+1])
      );
   end

   assign nxt = '{cy: c[WIDTH], s: sum};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s         <= '0;
         cy        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            s  <= nxt.s;
            cy <= nxt.cy;
         end
      end
   end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH=1 and WIDTH=8.
// Expected values are hand-computed constants or a bench-side sum model.
module tb_full_adder;

   logic clk = 1'b0;
   logic rst_n;

   logic       iv1, a1, b1, c1;
   logic       s1, cy1, ov1;

   logic       iv8, c8;
   logic [7:0] a8, b8;
   logic [7:0] s8;
   logic       cy8, ov8;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv1),
      .a         (a1),
      .b         (b1),
      .cin       (c1),
      .s         (s1),
      .cy        (cy1),
      .out_valid (ov1)
   );

   full_adder #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv8),
      .a         (a8),
      .b         (b8),
      .cin       (c8),
      .s         (s8),
      .cy        (cy8),
      .out_valid (ov8)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // WIDTH=1 exhaustive expectations for abc = 000..111
   logic [7:0] exp_s1  = 8'b1001_0110;
   logic [7:0] exp_cy1 = 8'b1110_1000;

   logic [8:0] ref8;
   logic       ref_ov;
   logic [7:0] ra, rb;
   logic       rc, rv;

   initial begin
      rst_n = 1'b0;
      iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      iv8 = 1'b0; a8 = 8'h0; b8 = 8'h0; c8 = 1'b0;

      // Reset held two edges with valid all-ones inputs present
      iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      tick();
      tick();
      check("rst_s1", 64'(s1), 64'd0);
      check("rst_cy1", 64'(cy1), 64'd0);
      check("rst_ov1", 64'(ov1), 64'd0);
      check("rst_s8", 64'(s8), 64'd0);
      check("rst_ov8", 64'(ov8), 64'd0);

      rst_n = 1'b1;
      tick();
      check("rel_s1", 64'(s1), 64'd1);
      check("rel_cy1", 64'(cy1), 64'd1);
      check("rel_ov1", 64'(ov1), 64'd1);

      for (int i = 0; i < 8; i++) begin
         {a1, b1, c1} = 3'(i);
         iv1 = 1'b1;
         tick();
         check($sformatf("exh_s_%0d", i), 64'(s1), 64'(exp_s1[i]));
         check($sformatf("exh_cy_%0d", i), 64'(cy1), 64'(exp_cy1[i]));
         check($sformatf("exh_ov_%0d", i), 64'(ov1), 64'd1);
      end

      // Hold: idle cycle with different inputs must not disturb s/cy
      a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; iv1 = 1'b1;
      tick();
      check("hold_ld_s", 64'(s1), 64'd1);
      check("hold_ld_cy", 64'(cy1), 64'd0);
      iv1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      tick();
      check("hold_s", 64'(s1), 64'd1);
      check("hold_cy", 64'(cy1), 64'd0);
      check("hold_ov", 64'(ov1), 64'd0);
      tick();
      check("hold2_s", 64'(s1), 64'd1);
      check("hold2_cy", 64'(cy1), 64'd0);

      // Wide carry chain
      iv8 = 1'b1;
      a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
      tick();
      check("w_ff_00_1_s", 64'(s8), 64'h00);
      check("w_ff_00_1_cy", 64'(cy8), 64'd1);
      check("w_ff_00_1_ov", 64'(ov8), 64'd1);
      a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
      tick();
      check("w_ff_ff_1_s", 64'(s8), 64'hFF);
      check("w_ff_ff_1_cy", 64'(cy8), 64'd1);
      a8 = 8'h5A; b8 = 8'hA5; c8 = 1'b0;
      tick();
      check("w_5a_a5_0_s", 64'(s8), 64'hFF);
      check("w_5a_a5_0_cy", 64'(cy8), 64'd0);

      // Reset between two valid operations
      a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
      tick();
      check("mid_pre_s", 64'(s8), 64'h47);
      check("mid_pre_cy", 64'(cy8), 64'd0);
      rst_n = 1'b0;
      a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
      tick();
      check("mid_rst_s", 64'(s8), 64'h00);
      check("mid_rst_cy", 64'(cy8), 64'd0);
      check("mid_rst_ov", 64'(ov8), 64'd0);
      rst_n = 1'b1;
      tick();
      check("mid_post_s", 64'(s8), 64'h00);
      check("mid_post_cy", 64'(cy8), 64'd1);
      check("mid_post_ov", 64'(ov8), 64'd1);

      // Random back-to-back against a + b + cin model
      ref8   = {cy8, s8};
      ref_ov = ov8;
      for (int k = 0; k < 1000; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         a8 = ra; b8 = rb; c8 = rc; iv8 = rv;
         tick();
         if (rv) ref8 = 9'(ra) + 9'(rb) + 9'(rc);
         ref_ov = rv;
         check("rnd_s", 64'(s8), 64'(ref8[7:0]));
         check("rnd_cy", 64'(cy8), 64'(ref8[8]));
         check("rnd_ov", 64'(ov8), 64'(ref_ov));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered full adder: adds operands a and b plus carry-in cin, and produces sum s and carry-out cy.
- WIDTH=1 (default) is the classic 1-bit full adder; wider WIDTH gives a ripple-carry adder built from 1-bit cells.
- Leaf arithmetic block, used standalone or as a building block in datapaths needing a registered add with carry.

Parameters:
- WIDTH, 1, operand/sum width in bits; legal range 1..64.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  qualifies a, b, cin this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- s  output  WIDTH  registered sum.
- cy  output  1  registered carry-out of the MSB.
- out_valid  output  1  s/cy hold a result produced from a valid input.

Behaviour:
- Reset:
  - rst_n is sampled only on the rising clk edge.
  - While rst_n=0 at an edge: s=0, cy=0, out_valid=0.
  - Reset overrides in_valid at the same edge.
- Arithmetic:
  - {cy, s} = a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
  - Per bit i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]); c[0] = cin; cy = c[WIDTH].
- Latency:
  - Exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on s/cy at edge N.
  - They are visible until the next update, and out_valid=1 in the same cycle.
- Throughput: one new operation per cycle; back-to-back in_valid=1 cycles each produce a result.
- Hold:
  - Edge with in_valid=0 and rst_n=1: s and cy keep their previous values; out_valid goes to 0.
  - Outputs never change except on a clock edge.
- Wrap-around: all-ones + all-ones + 1 gives s = all-ones, cy = 1. All-ones + 0 + 1 gives s = 0, cy = 1.
- Reset mid-operation: an input accepted in the same cycle that reset is asserted is discarded; the first result after reset release needs a fresh in_valid.
- No X propagation from undriven a/b/cin while in_valid=0: the registers are not loaded.

Decomposition:
- Shared package full_adder_pkg:
  - constant FA_MAX_WIDTH = 64;
  - typedef for the {carry, sum} result record, parameterized via WIDTH at the use site.
- One combinational sub-module, fa_cell (ports a, b, ci -> s, co).
  - It implements the 1-bit equations above.
  - WIDTH copies are chained by generate loop in full_adder; the carry chain is purely combinational.
- Output registers live only in full_adder.

Test Plan:
- Exhaustive 1-bit (WIDTH=1): drive the 8 combinations of a,b,cin in order 000..111 with in_valid=1, one per cycle.
  - Required s,cy sequence one cycle later: 00, 10, 10, 01, 10, 01, 01, 11.
- Reset:
  - Assert rst_n=0 for 2 cycles with a=1,b=1,cin=1,in_valid=1: s=0, cy=0, out_valid=0.
  - After release with the same inputs: s=1, cy=1, out_valid=1 one cycle later.
- Hold: apply a=1,b=0,cin=0 valid, then in_valid=0 with a=1,b=1,cin=1.
  - Required: s=1, cy=0 persist; out_valid drops to 0.
- Wide carry chain (WIDTH=8):
  - a=8'hFF, b=8'h00, cin=1 -> s=8'h00, cy=1.
  - a=8'hFF, b=8'hFF, cin=1 -> s=8'hFF, cy=1.
  - a=8'h5A, b=8'hA5, cin=0 -> s=8'hFF, cy=0.
- Random back-to-back (WIDTH=8): 1000 cycles of random a/b/cin/in_valid.
  - Compare against the reference {cy,s} = a+b+cin delayed one cycle.
  - Check out_valid tracks in_valid delayed one cycle.
- Reset mid-stream: assert rst_n=0 for one edge between two valid operations.
  - Required: outputs 0 at that edge; the following valid op produces a correct result.
